// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled RX line, switch-selected frame format,
// delivers each byte with a one-cycle valid pulse plus parity/framing flags.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       SW0,
    input  logic       SW1,
    input  logic       SW2,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_check
        $error("uart_rx: DIV must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BREAK
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta, rx_s, rx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         sc_q, sc_d;
    logic [2:0]         bc_q, bc_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               cfg_par_q, cfg_par_d;
    logic               cfg_8_q, cfg_8_d;
    logic               cfg_2s_q, cfg_2s_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic [7:0]         data_d;
    logic               valid_d, parity_err_d, frame_err_d, busy_d;
    logic               fall_c, tick_c, sample_c, start_c, load_c;

    // Synchronizer, edge register and all state; line flops reset to idle-high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            sc_q       <= '0;
            bc_q       <= '0;
            shreg_q    <= '0;
            cfg_par_q  <= 1'b0;
            cfg_8_q    <= 1'b0;
            cfg_2s_q   <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_meta    <= RX;
            rx_s       <= rx_meta;
            rx_d       <= rx_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sc_q       <= sc_d;
            bc_q       <= bc_d;
            shreg_q    <= shreg_d;
            cfg_par_q  <= cfg_par_d;
            cfg_8_q    <= cfg_8_d;
            cfg_2s_q   <= cfg_2s_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_out   <= data_d;
            valid      <= valid_d;
            parity_err <= parity_err_d;
            frame_err  <= frame_err_d;
            busy       <= busy_d;
        end
    end

    // Next-state, counters and output loads
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sc_d         = sc_q;
        bc_d         = bc_q;
        shreg_d      = shreg_q;
        cfg_par_d    = cfg_par_q;
        cfg_8_d      = cfg_8_q;
        cfg_2s_d     = cfg_2s_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        data_d       = data_out;
        valid_d      = 1'b0;
        parity_err_d = parity_err;
        frame_err_d  = frame_err;
        start_c      = 1'b0;
        load_c       = 1'b0;

        fall_c   = rx_d & ~rx_s;
        tick_c   = (state_q != IDLE) && (cnt_q == CNT_W'(DIV - 1));
        sample_c = tick_c && (sc_q == 4'd15);

        if (state_q == IDLE || tick_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (tick_c) begin
            sc_d = sc_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fall_c) start_c = 1'b1;
            end
            START: begin
                if (tick_c && sc_q == 4'd7) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        sc_d    = '0;
                    end
                end
            end
            DATA: begin
                if (sample_c) begin
                    shreg_d = {shreg_q[6:0], rx_s};
                    bc_d    = bc_q + 1'b1;
                    if (bc_q == (cfg_8_q ? 3'd7 : 3'd6)) begin
                        state_d = cfg_par_q ? PARITY : STOP1;
                    end
                end
            end
            PARITY: begin
                if (sample_c) begin
                    perr_d  = (^shreg_q) ^ rx_s;
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (sample_c) begin
                    ferr_d  = ~rx_s;
                    state_d = cfg_2s_q ? STOP2 : DONE;
                    load_c  = ~cfg_2s_q;
                end
            end
            STOP2: begin
                if (sample_c) begin
                    ferr_d  = ferr_q | ~rx_s;
                    state_d = DONE;
                    load_c  = 1'b1;
                end
            end
            DONE: begin
                // A start edge coinciding with DONE is taken immediately
                if (fall_c) begin
                    start_c = 1'b1;
                end else if (!rx_s) begin
                    state_d = BREAK;
                end else begin
                    state_d = IDLE;
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start_c) begin
            state_d   = START;
            cnt_d     = '0;
            sc_d      = '0;
            bc_d      = '0;
            shreg_d   = '0;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
            cfg_par_d = SW0;
            cfg_8_d   = SW1;
            cfg_2s_d  = SW2;
        end

        if (load_c) begin
            data_d       = shreg_q;
            valid_d      = 1'b1;
            parity_err_d = perr_d;
            frame_err_d  = ferr_d;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int unsigned BIT_CLK = 16;

    typedef struct packed {
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        logic [31:0] t;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst, RX, SW0, SW1, SW2;
    logic [7:0] data_out;
    logic       valid, parity_err, frame_err, busy;

    rec_t        q[$];
    int unsigned cyc = 0;
    int unsigned busy_cnt = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    uart_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
        .clk(clk), .rst(rst), .RX(RX), .SW0(SW0), .SW1(SW1), .SW2(SW2),
        .data_out(data_out), .valid(valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid cycle and count busy cycles, sampled mid-period
    always @(negedge clk) begin
        rec_t r;
        if (valid) begin
            r.d = data_out; r.pe = parity_err; r.fe = frame_err; r.t = cyc;
            q.push_back(r);
        end
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    // Leaves RX at the last stop-bit level
    task automatic send_frame(input logic [7:0] d, input bit eight, input bit par,
                              input logic pbit, input bit two, input logic s1, input logic s2);
        int n;
        n = eight ? 8 : 7;
        send_bit(1'b0);
        for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
        if (par) send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
    endtask

    function automatic rec_t model(input logic [7:0] d, input bit par, input bit eight,
                                   input bit two, input logic pbit, input logic s1, input logic s2);
        rec_t r;
        r.d  = eight ? d : {1'b0, d[6:0]};
        r.pe = par ? ((^r.d) ^ pbit) : 1'b0;
        r.fe = !s1 || (two && !s2);
        r.t  = '0;
        return r;
    endfunction

    task automatic expect_frame(input string tag, input rec_t e);
        rec_t r;
        check({tag, " valid_count"}, 32'(q.size()), 32'd1);
        if (q.size() > 0) begin
            r = q.pop_front();
            check({tag, " data_out"}, 32'(r.d), 32'(e.d));
            check({tag, " parity_err"}, 32'(r.pe), 32'(e.pe));
            check({tag, " frame_err"}, 32'(r.fe), 32'(e.fe));
        end
        q.delete();
    endtask

    initial begin
        rec_t e, r0, r1;
        logic [7:0] d;
        bit s0b, s1b, s2b, flip;
        logic pb, st1, st2;

        rst = 1'b0; RX = 1'b1; SW0 = 1'b0; SW1 = 1'b0; SW2 = 1'b0;
        idle(3);
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset valid", 32'(valid), 32'd0);
        check("reset parity_err", 32'(parity_err), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b1;
        idle(5);

        // 7-bit, no parity, one stop
        busy_cnt = 0;
        check("t1 busy_before", 32'(busy), 32'd0);
        send_frame(8'h55, 0, 0, 1'b0, 0, 1'b1, 1'b1);
        RX = 1'b1; idle(8);
        expect_frame("t1", model(8'h55, 0, 0, 0, 1'b0, 1'b1, 1'b1));
        check("t1 busy_after", 32'(busy), 32'd0);
        check("t1 busy_len_ok", 32'(busy_cnt >= 9*BIT_CLK-12 && busy_cnt <= 9*BIT_CLK-4), 32'd1);

        // 8-bit even parity, good then bad parity bit
        SW0 = 1'b1; SW1 = 1'b1; SW2 = 1'b0; idle(4);
        send_frame(8'hA7, 1, 1, 1'b1, 0, 1'b1, 1'b1);
        RX = 1'b1; idle(8);
        expect_frame("t2a", '{d: 8'hA7, pe: 1'b0, fe: 1'b0, t: 32'd0});
        send_frame(8'hA7, 1, 1, 1'b0, 0, 1'b1, 1'b1);
        RX = 1'b1; idle(8);
        expect_frame("t2b", '{d: 8'hA7, pe: 1'b1, fe: 1'b0, t: 32'd0});

        // Second stop bit low, then line held low (break)
        SW0 = 1'b0; SW1 = 1'b1; SW2 = 1'b1; idle(4);
        send_frame(8'h5A, 1, 0, 1'b0, 1, 1'b1, 1'b0);
        idle(30 * BIT_CLK);
        expect_frame("t3 break", '{d: 8'h5A, pe: 1'b0, fe: 1'b1, t: 32'd0});
        check("t3 busy_in_break", 32'(busy), 32'd1);
        RX = 1'b1; idle(20);
        check("t3 busy_after_break", 32'(busy), 32'd0);
        check("t3 no_valid_after_break", 32'(q.size()), 32'd0);
        send_frame(8'hC3, 1, 0, 1'b0, 1, 1'b1, 1'b1);
        RX = 1'b1; idle(8);
        expect_frame("t3 post", '{d: 8'hC3, pe: 1'b0, fe: 1'b0, t: 32'd0});

        // Short glitch on idle line
        busy_cnt = 0;
        RX = 1'b0; idle(3); RX = 1'b1; idle(30);
        check("t4 glitch no_valid", 32'(q.size()), 32'd0);
        check("t4 glitch busy_pulse_ok", 32'(busy_cnt >= 1 && busy_cnt <= 12), 32'd1);
        check("t4 glitch busy_low", 32'(busy), 32'd0);

        // Back-to-back 8-bit frames, SW1 toggled during the first
        SW0 = 1'b0; SW1 = 1'b1; SW2 = 1'b0; idle(4);
        q.delete();
        fork
            begin
                send_frame(8'h00, 1, 0, 1'b0, 0, 1'b1, 1'b1);
                send_frame(8'hFF, 1, 0, 1'b0, 0, 1'b1, 1'b1);
            end
            begin
                idle(40); SW1 = 1'b0; idle(60); SW1 = 1'b1;
            end
        join
        RX = 1'b1; idle(10);
        check("t5 valid_count", 32'(q.size()), 32'd2);
        if (q.size() == 2) begin
            r0 = q.pop_front();
            r1 = q.pop_front();
            check("t5 first data", 32'(r0.d), 32'h00);
            check("t5 second data", 32'(r1.d), 32'hFF);
            check("t5 errors", 32'({r0.pe, r0.fe, r1.pe, r1.fe}), 32'd0);
            check("t5 spacing", r1.t - r0.t, 32'd160);
        end
        q.delete();

        // Reset during DATA
        fork
            send_frame(8'h3C, 1, 0, 1'b0, 0, 1'b1, 1'b1);
            begin
                idle(4 * BIT_CLK + 5);
                check("t6 busy_before_rst", 32'(busy), 32'd1);
                #3 rst = 1'b0;
                #1;
                check("t6 rst data_out", 32'(data_out), 32'h00);
                check("t6 rst busy", 32'(busy), 32'd0);
                check("t6 rst valid", 32'(valid), 32'd0);
                check("t6 rst flags", 32'({parity_err, frame_err}), 32'd0);
            end
        join
        RX = 1'b1; idle(10); rst = 1'b1; idle(10);
        check("t6 no_valid", 32'(q.size()), 32'd0);
        send_frame(8'h3C, 1, 0, 1'b0, 0, 1'b1, 1'b1);
        RX = 1'b1; idle(8);
        expect_frame("t6 post", '{d: 8'h3C, pe: 1'b0, fe: 1'b0, t: 32'd0});

        // Randomized frames against the reference model
        for (int i = 0; i < 16; i++) begin
            s0b  = 1'($urandom_range(0, 1));
            s1b  = 1'($urandom_range(0, 1));
            s2b  = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            pb   = (^(s1b ? d : {1'b0, d[6:0]})) ^ flip;
            st1  = ($urandom_range(0, 4) != 0);
            st2  = ($urandom_range(0, 4) != 0);
            SW0 = s0b; SW1 = s1b; SW2 = s2b;
            idle(2);
            e = model(d, s0b, s1b, s2b, pb, st1, st2);
            send_frame(d, s1b, s0b, pb, s2b, st1, st2);
            RX = 1'b1;
            idle(int'($urandom_range(2, 20)));
            expect_frame($sformatf("rand%0d", i), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver and frame checker for the board UART link. It recovers frames sent by the team's transmitter path and uses the same switch-selected frame formats. It oversamples the asynchronous `RX` line at 16× the baud rate, checks the start bit, parity and stop bits, and delivers each byte with a one-cycle valid pulse and error flags to the downstream consumer (display/loopback logic).

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line bit rate.
- `DIV`, default CLK_FREQ/(BAUD*16): clocks per oversample tick; must be ≥1 (elaboration-time check).

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `RX`, input, 1: serial line; idles high; asynchronous to `clk`.
- `SW0`, input, 1: 1 = even parity bit present after the data bits; 0 = no parity.
- `SW1`, input, 1: 1 = 8 data bits; 0 = 7 data bits.
- `SW2`, input, 1: 1 = two stop bits checked; 0 = one stop bit.
- `data_out`, output, 8: last received character; held until the next accepted frame.
- `valid`, output, 1: one-cycle pulse when `data_out`/error flags update.
- `parity_err`, output, 1: parity mismatch for the frame flagged by `valid`.
- `frame_err`, output, 1: a stop bit was sampled low for the frame flagged by `valid`.
- `busy`, output, 1: high from start-bit detection until return to IDLE.

## Operation
- `RX` passes through a 2-flop synchronizer, then an edge register. All logic uses the synchronized value `rx_s`.
- Tick generator: counter 0..DIV-1. `tick` is asserted for one clk when the counter wraps. The counter runs freely only while not IDLE and is cleared on start detection.
- Sample counter `sc` (4 bit) counts ticks within a bit. A bit is sampled at `sc`=7 (start) and at `sc`=15 thereafter, which gives mid-bit sampling 16 ticks apart.
- Configuration (`SW0..SW2`) is latched at start detection. Switch changes mid-frame do not affect the current frame.
- FSM states:
  - IDLE: on falling edge of `rx_s` → START, `busy`=1.
  - START: at `sc`=7, if `rx_s`=1 (glitch) → IDLE with no `valid`. Otherwise reset `sc` and go to DATA.
  - DATA: sample N bits (N=8 if SW1, else 7). Bits arrive MSB first. In 8-bit mode the first bit lands in `data_out[7]`. In 7-bit mode the first bit lands in `data_out[6]` and `data_out[7]`=0. After the last bit → PARITY if SW0, else STOP1.
  - PARITY: sample bit. `parity_err` = XOR(data bits, parity bit) ≠ 0.
  - STOP1: sample bit; low → `frame_err`. → STOP2 if SW2, else DONE.
  - STOP2: sample bit; low → `frame_err` (OR with STOP1 result). → DONE.
  - DONE: one cycle. Load `data_out`, `parity_err`, `frame_err`; pulse `valid`. If `rx_s`=0 → BREAK, else → IDLE.
  - BREAK: wait for `rx_s`=1, then → IDLE. No new start is detected during BREAK.
- Frames with errors are still delivered (`valid`=1, flags set). `parity_err`=0 when SW0=0.
- A falling edge in the same cycle as the DONE→IDLE transition is not lost: DONE checks for the edge and goes straight to START.
- Reset values: `data_out`=8'h00, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, FSM=IDLE, counters=0. Asserting `rst` mid-frame aborts the frame immediately with no `valid`.

## Timing
- Synchronizer latency: 2 clk. Start detection: 3 clk after the `RX` falling edge.
- One bit = 16·DIV clk. Start confirmation occurs 8·DIV clk after detection.
- `valid` rises in the clk after the final stop-bit sample (DONE state). That sample falls at mid-bit, about 0.5 bit before the end of the line frame.
- `busy` falls in the clk after DONE (IDLE), or when BREAK exits.
- Frame length: 1+N+P+S bits (P∈{0,1}, S∈{1,2}). Back-to-back frames with no idle gap are received without loss.
- Tolerated baud mismatch: ±3% for 11-bit frames.

## Test plan
For all scenarios below: CLK_FREQ=1_600_000, BAUD=100_000 (DIV=1, 16 clk/bit).
- SW=000, send 7-bit 7'h55 (1 stop) → `valid` pulse, `data_out`=8'h55, both errors 0; `busy` high throughout the frame only.
- SW=110 (parity, 8-bit, 1 stop), send 8'hA7 with correct parity bit 1 → `data_out`=8'hA7, `parity_err`=0. Repeat with parity bit 0 → `parity_err`=1, `valid` still pulses.
- SW=011 (no parity, 8-bit, 2 stop), second stop bit driven low → `frame_err`=1. Line then held low for 30 bits → no further `valid` until `RX` returns high and a new frame arrives.
- 3-clk low glitch on idle `RX` → FSM returns to IDLE, no `valid`, `busy` pulses high for ≤12 clk.
- Two back-to-back 8-bit frames 8'h00 then 8'hFF, no gap → two `valid` pulses 160 clk apart with the correct data. Toggle SW1 during the first frame → first frame decoded in the latched mode.
- `rst` low during the DATA state → all outputs at reset values asynchronously; the next full frame decodes correctly.
